// File: rtl/pci_bus_arbiter_if.sv
// Arbiter-facing bundle of the shared PCI bus: per-device REQ#/GNT#, FRAME#/IRDY# and arbiter status.
// The master modport is the arbiter's view; the slave modport is the device/bus-model view.
interface pci_bus_arbiter_if #(
   parameter int NUM_DEV = 4
);
   logic [NUM_DEV-1:0]         req;
   logic                       frame;
   logic                       irdy;
   logic [NUM_DEV-1:0]         gnt;
   logic [$clog2(NUM_DEV)-1:0] owner;
   logic                       bus_busy;

   modport master (
      input  req,
      input  frame,
      input  irdy,
      output gnt,
      output owner,
      output bus_busy
   );

   modport slave (
      output req,
      output frame,
      output irdy,
      input  gnt,
      input  owner,
      input  bus_busy
   );
endinterface

// File: rtl/pci_bus_arbiter.sv
// Central round-robin PCI bus arbiter with unused-grant timeout and a forced idle gap between owners.
// NUM_DEV must be a power of two so the pointer and owner arithmetic wrap naturally.
module pci_bus_arbiter #(
   parameter int NUM_DEV = 4,
   parameter int TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   pci_bus_arbiter_if.master  bus
);

   localparam int             IW    = $clog2(NUM_DEV);
   localparam logic [3:0]     TLAST = 4'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      BUSY
   } state_t;

   state_t             state_q, state_d;
   logic [NUM_DEV-1:0] gnt_q, gnt_d;
   logic [IW-1:0]      owner_q, owner_d;
   logic [IW-1:0]      ptr_q, ptr_d;
   logic [3:0]         tcnt_q, tcnt_d;
   logic               busy_q, busy_d;

   logic [IW-1:0]      sel;
   logic [IW-1:0]      cand;
   logic               found;
   logic               any_req;
   logic               bus_idle;
   logic [IW-1:0]      owner_inc;
   logic               owner_req;
   logic               other_req;
   logic [NUM_DEV-1:0] owner_mask;
   logic [NUM_DEV-1:0] sel_gnt;

   assign any_req   = ~&bus.req;
   assign bus_idle  = bus.frame & bus.irdy;
   assign owner_inc = owner_q + 1'b1;
   assign owner_req = ~bus.req[owner_q];

   // Round-robin search starting at the pointer; the first low req wins.
   always_comb begin
      sel   = '0;
      cand  = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_DEV; i++) begin
         cand = ptr_q + IW'(i);
         if (!found && !bus.req[cand]) begin
            sel   = cand;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      owner_mask          = '0;
      owner_mask[owner_q] = 1'b1;
      sel_gnt             = '1;
      sel_gnt[sel]        = 1'b0;
   end

   assign other_req = ~&(bus.req | owner_mask);

   // Next-state logic; every register defaults to holding its value.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      tcnt_d  = tcnt_q;
      busy_d  = busy_q;

      case (state_q)
         IDLE: begin
            gnt_d  = '1;
            busy_d = 1'b0;
            // A FRAME# seen in IDLE belongs to nobody we granted, so wait for a quiet bus.
            if (any_req && bus_idle) begin
               gnt_d   = sel_gnt;
               owner_d = sel;
               tcnt_d  = '0;
               state_d = GRANT;
            end
         end

         GRANT: begin
            if (!bus.frame) begin
               state_d = BUSY;
               busy_d  = 1'b1;
               ptr_d   = owner_inc;
            end else if (!owner_req) begin
               gnt_d   = '1;
               state_d = IDLE;
            end else if (tcnt_q == TLAST) begin
               gnt_d   = '1;
               ptr_d   = owner_inc;
               state_d = IDLE;
            end else if (tcnt_q != 4'hF) begin
               tcnt_d  = tcnt_q + 4'd1;
            end
         end

         BUSY: begin
            // Once released, gnt stays high; the owner completes its transaction without it.
            if (bus_idle) begin
               gnt_d   = '1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else if (!owner_req || other_req) begin
               gnt_d   = '1;
            end
         end

         default: begin
            gnt_d   = '1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         gnt_q   <= '1;
         owner_q <= '0;
         ptr_q   <= '0;
         tcnt_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         tcnt_q  <= tcnt_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.gnt      = gnt_q;
   assign bus.owner    = owner_q;
   assign bus.bus_busy = busy_q;

   a_gnt_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
      $countones(~gnt_q) <= 1);

   a_busy_tracks_state: assert property (@(posedge clk) disable iff (!reset_n)
      busy_q == (state_q == BUSY));

   a_idle_no_grant: assert property (@(posedge clk) disable iff (!reset_n)
      (state_q == IDLE) |-> (gnt_q == '1));

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Scoreboard bench for pci_bus_arbiter: directed bus scenarios queue expected output changes,
// and a negedge monitor pops and compares them whenever gnt/owner/bus_busy change.
module tb_pci_bus_arbiter;

   localparam int NUM_DEV = 4;
   localparam int TIMEOUT = 16;

   typedef struct {
      int         cyc;
      logic [3:0] gnt;
      logic [1:0] owner;
      logic       busy;
      string      tag;
   } exp_t;

   exp_t       sb_q[$];
   exp_t       e;
   logic       clk = 1'b0;
   logic       reset_n;
   logic       armed = 1'b0;
   int         cyc = 0;
   int         checks = 0;
   int         failures = 0;
   int         k;
   logic [3:0] last_gnt = 4'hF;
   logic [1:0] last_owner = 2'd0;
   logic       last_busy = 1'b0;
   logic [3:0] prev_gnt = 4'hF;
   logic [3:0] gnt_of [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   pci_bus_arbiter_if #(.NUM_DEV(NUM_DEV)) bus ();

   pci_bus_arbiter #(
      .NUM_DEV (NUM_DEV),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic step();
      @(negedge clk);
   endtask

   // Advance to the negedge just before edge c so inputs set now are sampled at c.
   task automatic toEdge(input int c);
      while (cyc < c - 1) step();
   endtask

   task automatic applyStimulus(input logic [3:0] r, input logic f, input logic i);
      bus.req   = r;
      bus.frame = f;
      bus.irdy  = i;
   endtask

   task automatic expectEvent(input int c, input logic [3:0] g, input logic [1:0] o,
                              input logic b, input string tag);
      sb_q.push_back('{c, g, o, b, tag});
   endtask

   task automatic checkOutput(input string name, input logic [3:0] g, input logic [1:0] o,
                              input logic b);
      checks++;
      if (bus.gnt !== g || bus.owner !== o || bus.bus_busy !== b) begin
         failures++;
         $display("[TB] FAIL %s: got gnt=%b owner=%0d busy=%b, want gnt=%b owner=%0d busy=%b",
                  name, bus.gnt, bus.owner, bus.bus_busy, g, o, b);
      end
   endtask

   task automatic doReset();
      applyStimulus(4'b1111, 1'b1, 1'b1);
      reset_n = 1'b0;
      step();
      step();
      checkOutput("reset_values", 4'b1111, 2'd0, 1'b0);
      reset_n = 1'b1;
      step();
   endtask

   // Monitor: grant protocol every cycle, scoreboard pop on every output change.
   always @(negedge clk) begin
      if (armed) begin
         checks++;
         if ($countones(~bus.gnt) > 1 ||
             (prev_gnt != 4'hF && bus.gnt != 4'hF && bus.gnt != prev_gnt)) begin
            failures++;
            $display("[TB] FAIL gnt_protocol cyc=%0d: got gnt=%b after %b, want at most one low bit and an all-high gap between owners",
                     cyc, bus.gnt, prev_gnt);
         end
         prev_gnt = bus.gnt;

         if (reset_n && (bus.gnt !== last_gnt || bus.owner !== last_owner ||
                         bus.bus_busy !== last_busy)) begin
            checks++;
            if (sb_q.size() == 0) begin
               failures++;
               $display("[TB] FAIL unexpected_change cyc=%0d: got gnt=%b owner=%0d busy=%b, want no change",
                        cyc, bus.gnt, bus.owner, bus.bus_busy);
            end else begin
               e = sb_q.pop_front();
               if (e.cyc != cyc || e.gnt !== bus.gnt || e.owner !== bus.owner ||
                   e.busy !== bus.bus_busy) begin
                  failures++;
                  $display("[TB] FAIL %s: got cyc=%0d gnt=%b owner=%0d busy=%b, want cyc=%0d gnt=%b owner=%0d busy=%b",
                           e.tag, cyc, bus.gnt, bus.owner, bus.bus_busy,
                           e.cyc, e.gnt, e.owner, e.busy);
               end
            end
         end
         last_gnt   = bus.gnt;
         last_owner = bus.owner;
         last_busy  = bus.bus_busy;
      end
   end

   initial begin
      #100000;
      failures++;
      $display("[TB] FAIL watchdog: got no end of stimulus, want completion before 100000 time units");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      applyStimulus(4'b1111, 1'b1, 1'b1);
      reset_n = 1'b1;
      #1;
      reset_n = 1'b0;
      armed   = 1'b1;
      step();
      doReset();

      // Single request, short transaction.
      $display("[TB] single request");
      k = cyc + 1;
      applyStimulus(4'b1110, 1'b1, 1'b1);
      expectEvent(k, 4'b1110, 2'd0, 1'b0, "s1_grant");
      toEdge(k + 2); applyStimulus(4'b1110, 1'b0, 1'b1);
      expectEvent(k + 2, 4'b1110, 2'd0, 1'b1, "s1_busy");
      toEdge(k + 3); applyStimulus(4'b1110, 1'b0, 1'b0);
      toEdge(k + 4); applyStimulus(4'b1110, 1'b1, 1'b0);
      toEdge(k + 5); applyStimulus(4'b1111, 1'b1, 1'b1);
      expectEvent(k + 5, 4'b1111, 2'd0, 1'b0, "s1_idle");
      toEdge(k + 8);
      doReset();

      // Round robin with every device requesting continuously.
      $display("[TB] round robin");
      k = cyc + 1;
      applyStimulus(4'b0000, 1'b1, 1'b1);
      expectEvent(k, gnt_of[0], 2'd0, 1'b0, "rr_grant_0");
      for (int i = 0; i < 4; i++) begin
         toEdge(k + 1); applyStimulus(4'b0000, 1'b0, 1'b1);
         expectEvent(k + 1, gnt_of[i], 2'(i), 1'b1, "rr_busy");
         toEdge(k + 2); applyStimulus(4'b0000, 1'b1, 1'b0);
         expectEvent(k + 2, 4'b1111, 2'(i), 1'b1, "rr_release");
         toEdge(k + 3); applyStimulus(4'b0000, 1'b1, 1'b1);
         expectEvent(k + 3, 4'b1111, 2'(i), 1'b0, "rr_idle");
         expectEvent(k + 4, gnt_of[(i + 1) % 4], 2'((i + 1) % 4), 1'b0, "rr_next_grant");
         k = k + 4;
      end
      toEdge(k + 1); applyStimulus(4'b1111, 1'b1, 1'b1);
      expectEvent(k + 1, 4'b1111, 2'd0, 1'b0, "rr_withdraw");
      toEdge(k + 3);

      // Unused grant times out twice; then device 3 beats device 1.
      $display("[TB] timeout");
      k = cyc + 1;
      applyStimulus(4'b1101, 1'b1, 1'b1);
      expectEvent(k, 4'b1101, 2'd1, 1'b0, "to_grant");
      expectEvent(k + 16, 4'b1111, 2'd1, 1'b0, "to_revoke");
      expectEvent(k + 17, 4'b1101, 2'd1, 1'b0, "to_regrant");
      expectEvent(k + 33, 4'b1111, 2'd1, 1'b0, "to_revoke2");
      toEdge(k + 34); applyStimulus(4'b0101, 1'b1, 1'b1);
      expectEvent(k + 34, 4'b0111, 2'd3, 1'b0, "to_dev3_wins");
      toEdge(k + 35); applyStimulus(4'b1111, 1'b1, 1'b1);
      expectEvent(k + 35, 4'b1111, 2'd3, 1'b0, "to_withdraw");
      toEdge(k + 37);

      // Withdrawal on the same edge FRAME# falls: frame wins.
      $display("[TB] withdraw vs frame");
      k = cyc + 1;
      applyStimulus(4'b1011, 1'b1, 1'b1);
      expectEvent(k, 4'b1011, 2'd2, 1'b0, "col_grant");
      toEdge(k + 1); applyStimulus(4'b1111, 1'b0, 1'b1);
      expectEvent(k + 1, 4'b1011, 2'd2, 1'b1, "col_busy");
      expectEvent(k + 2, 4'b1111, 2'd2, 1'b1, "col_release");
      toEdge(k + 2); applyStimulus(4'b1111, 1'b1, 1'b0);
      toEdge(k + 3); applyStimulus(4'b1111, 1'b1, 1'b1);
      expectEvent(k + 3, 4'b1111, 2'd2, 1'b0, "col_idle");
      toEdge(k + 5);

      // Device 0 pre-empts device 2's grant during its transaction.
      $display("[TB] pre-emption");
      k = cyc + 1;
      applyStimulus(4'b1011, 1'b1, 1'b1);
      expectEvent(k, 4'b1011, 2'd2, 1'b0, "pre_grant");
      toEdge(k + 1); applyStimulus(4'b1011, 1'b0, 1'b1);
      expectEvent(k + 1, 4'b1011, 2'd2, 1'b1, "pre_busy");
      toEdge(k + 2); applyStimulus(4'b1010, 1'b0, 1'b0);
      expectEvent(k + 2, 4'b1111, 2'd2, 1'b1, "pre_release");
      toEdge(k + 3); applyStimulus(4'b1010, 1'b0, 1'b0);
      toEdge(k + 4); applyStimulus(4'b1010, 1'b1, 1'b0);
      toEdge(k + 5); applyStimulus(4'b1110, 1'b1, 1'b1);
      expectEvent(k + 5, 4'b1111, 2'd2, 1'b0, "pre_idle");
      expectEvent(k + 6, 4'b1110, 2'd0, 1'b0, "pre_grant0");
      toEdge(k + 7); applyStimulus(4'b1111, 1'b1, 1'b1);
      expectEvent(k + 7, 4'b1111, 2'd0, 1'b0, "pre_withdraw");
      toEdge(k + 9);

      // FRAME# low while IDLE: no grant until the bus goes quiet.
      $display("[TB] frame in idle");
      k = cyc + 1;
      applyStimulus(4'b1110, 1'b0, 1'b0);
      toEdge(k + 3); applyStimulus(4'b1110, 1'b1, 1'b1);
      expectEvent(k + 3, 4'b1110, 2'd0, 1'b0, "oop_grant");
      toEdge(k + 4); applyStimulus(4'b1111, 1'b1, 1'b1);
      expectEvent(k + 4, 4'b1111, 2'd0, 1'b0, "oop_withdraw");
      toEdge(k + 6);

      // Asynchronous reset in the middle of device 1's transaction.
      $display("[TB] async reset mid-busy");
      k = cyc + 1;
      applyStimulus(4'b1101, 1'b1, 1'b1);
      expectEvent(k, 4'b1101, 2'd1, 1'b0, "ar_grant");
      toEdge(k + 1); applyStimulus(4'b1101, 1'b0, 1'b1);
      expectEvent(k + 1, 4'b1101, 2'd1, 1'b1, "ar_busy");
      toEdge(k + 2);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("async_reset", 4'b1111, 2'd0, 1'b0);
      applyStimulus(4'b1111, 1'b1, 1'b1);
      step();
      step();
      checkOutput("reset_hold", 4'b1111, 2'd0, 1'b0);
      reset_n = 1'b1;
      step();
      step();

      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("[TB] FAIL sb_drain: got %0d expected events never observed, want 0 (next: %s)",
                  sb_q.size(), sb_q[0].tag);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
